// File: rtl/serial_pattern_pkg.sv
// Shared state encoding for the serial pattern generator.
package serial_pattern_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/serial_pattern_generator_piso.sv
// Parallel-in serial-out shift register, MSB first; q is the current MSB.
module piso_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         q
);

  logic [W-1:0] sr_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_reg <= '0;
    end else if (load) begin
      sr_reg <= din;
    end else if (shift) begin
      sr_reg <= {sr_reg[W-2:0], 1'b0};
    end
  end

  assign q = sr_reg[W-1];

endmodule

// File: rtl/serial_pattern_generator.sv
// Serial pattern source: sends a captured pattern MSB-first repeat_n times with
// optional idle gaps, using a start/busy/done handshake and a synchronous abort.
module serial_pattern_generator
  import serial_pattern_pkg::*;
#(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int BIT_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(PAT_W - 1);

  state_t             state_reg;
  logic [BIT_W-1:0]   bit_cnt_reg;
  logic [CNT_W-1:0]   rem_reg;
  logic [GAP_W-1:0]   gap_cnt_reg;
  logic [PAT_W-1:0]   pattern_reg;
  logic [GAP_W-1:0]   gap_reg;
  logic               out_valid_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               accept;
  logic               last_bit;
  logic               rem_last;
  logic               gap_end;
  logic               sr_load;
  logic               sr_shift;
  logic [PAT_W-1:0]   sr_din;
  logic               sr_q;

  assign accept   = (state_reg == S_IDLE) && start && (repeat_n != '0) && !abort;
  assign last_bit = (bit_cnt_reg == BIT_MAX);
  assign rem_last = (rem_reg == CNT_W'(1));
  assign gap_end  = (gap_cnt_reg == '0);

  // The shift register is cleared whenever no bit is being sent, so its MSB
  // doubles as the registered serial output and is 0 outside valid cycles.
  always_comb begin
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = pattern_reg;
    if (abort) begin
      sr_load = 1'b1;
      sr_din  = '0;
    end else begin
      unique case (state_reg)
        S_IDLE: begin
          if (accept) begin
            sr_load = 1'b1;
            sr_din  = pattern;
          end
        end
        S_SHIFT: begin
          if (!last_bit) begin
            sr_shift = 1'b1;
          end else begin
            sr_load = 1'b1;
            sr_din  = (!rem_last && gap_reg == '0) ? pattern_reg : '0;
          end
        end
        S_GAP: begin
          sr_load = gap_end;
        end
        default: begin
          sr_load = 1'b1;
          sr_din  = '0;
        end
      endcase
    end
  end

  piso_shift_reg #(.W(PAT_W)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sr_load),
    .shift (sr_shift),
    .din   (sr_din),
    .q     (sr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_IDLE;
      bit_cnt_reg   <= '0;
      rem_reg       <= '0;
      gap_cnt_reg   <= '0;
      pattern_reg   <= '0;
      gap_reg       <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        state_reg     <= S_IDLE;
        bit_cnt_reg   <= '0;
        rem_reg       <= '0;
        gap_cnt_reg   <= '0;
        out_valid_reg <= 1'b0;
        busy_reg      <= 1'b0;
      end else begin
        unique case (state_reg)
          S_IDLE: begin
            if (start) begin
              if (repeat_n != '0) begin
                pattern_reg   <= pattern;
                rem_reg       <= repeat_n;
                gap_reg       <= gap;
                bit_cnt_reg   <= '0;
                out_valid_reg <= 1'b1;
                busy_reg      <= 1'b1;
                state_reg     <= S_SHIFT;
              end else begin
                done_reg <= 1'b1;
              end
            end
          end
          S_SHIFT: begin
            if (!last_bit) begin
              bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
            end else begin
              bit_cnt_reg <= '0;
              rem_reg     <= rem_reg - CNT_W'(1);
              if (rem_last) begin
                state_reg     <= S_IDLE;
                out_valid_reg <= 1'b0;
                busy_reg      <= 1'b0;
                done_reg      <= 1'b1;
              end else if (gap_reg != '0) begin
                state_reg     <= S_GAP;
                out_valid_reg <= 1'b0;
                gap_cnt_reg   <= gap_reg - GAP_W'(1);
              end
            end
          end
          S_GAP: begin
            if (gap_end) begin
              state_reg     <= S_SHIFT;
              out_valid_reg <= 1'b1;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
            end
          end
          default: begin
            state_reg     <= S_IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out       = sr_q;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
